// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: restoring radix-2, one quotient bit per cycle,
// valid/ready request and response handshakes with flush.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       fn,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       LAST_BIT = 6'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // |MIN_NEG| wraps back to MIN_NEG, which is correct once read as unsigned.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? f_neg(x) : x;
    endfunction

    logic [1:0]       r_state;
    logic [5:0]       r_count;
    logic [1:0]       r_fn;
    logic             r_sign1;
    logic             r_sign2;
    logic             r_special;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_out;
    logic             r_req_ready;
    logic             r_resp_valid;

    logic             w_signed;
    logic             w_accept;
    logic             w_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_result;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign out        = r_out;

    // Accept decode, special-case results, one subtract step and sign fix-up.
    always_comb begin
        w_signed = (fn[0] == 1'b0);
        w_accept = req_valid && r_req_ready && !flush;
        w_zero   = (in2 == ZERO);
        w_ovf    = w_signed && (in1 == MIN_NEG) && (in2 == ALL_ONES);
        if (w_zero) begin
            w_special_res = fn[1] ? in1 : ALL_ONES;
        end else if (w_ovf) begin
            w_special_res = fn[1] ? ZERO : MIN_NEG;
        end else begin
            w_special_res = ZERO;
        end
        // Subtract one bit wider than the shifted remainder so the top bit is the borrow.
        w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
        w_borrow  = w_diff[WIDTH+1];
        w_quo_fix = (!r_fn[0] && (r_sign1 ^ r_sign2)) ? f_neg(r_quo) : r_quo;
        w_rem_fix = (!r_fn[0] && r_sign1) ? f_neg(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
        if (r_special) begin
            w_result = r_quo;
        end else if (r_fn[1]) begin
            w_result = w_rem_fix;
        end else begin
            w_result = w_quo_fix;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 6'd0;
            r_fn         <= 2'd0;
            r_sign1      <= 1'b0;
            r_sign2      <= 1'b0;
            r_special    <= 1'b0;
            r_quo        <= ZERO;
            r_rem        <= {(WIDTH+1){1'b0}};
            r_dvs        <= ZERO;
            r_out        <= ZERO;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_count      <= 6'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_fn        <= fn;
                        r_sign1     <= w_signed && in1[WIDTH-1];
                        r_sign2     <= w_signed && in2[WIDTH-1];
                        r_rem       <= {(WIDTH+1){1'b0}};
                        // Special cases skip the iteration; FIX just registers the result.
                        if (w_zero || w_ovf) begin
                            r_special <= 1'b1;
                            r_quo     <= w_special_res;
                            r_dvs     <= ZERO;
                            r_count   <= 6'd0;
                            r_state   <= S_FIX;
                        end else begin
                            r_special <= 1'b0;
                            r_quo     <= w_signed ? f_abs(in1) : in1;
                            r_dvs     <= w_signed ? f_abs(in2) : in2;
                            r_count   <= LAST_BIT;
                            r_state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_borrow ? w_shift : w_diff[WIDTH:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                    if (r_count == 6'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count - 6'd1;
                    end
                end
                S_FIX: begin
                    r_out        <= w_result;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
